// File: rtl/tetris_pkg.sv
// Shared playfield constants, cell/address types and the RAM access-state enum.
// Used by the playfield arbiter and its tick divider.
package tetris_pkg;

    localparam int COLS      = 10;
    localparam int ROWS      = 20;
    localparam int CELL_BITS = 3;
    localparam int NCELLS    = COLS * ROWS;
    localparam int ADDR_W    = $clog2(NCELLS);

    typedef logic [CELL_BITS-1:0] cell_t;
    typedef logic [ADDR_W-1:0]    addr_t;

    typedef enum logic [1:0] {
        IDLE,
        VRD,
        GRD,
        GWR
    } acc_state_t;

    // Extra MSB keeps the compare correct when NCELLS is a power of two.
    function automatic logic in_range(input addr_t a);
        return {1'b0, a} < (ADDR_W + 1)'(NCELLS);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Gravity tick divider: counts frame strobes and emits a one-cycle tick
// in the cycle after every TICK_FRAMES-th strobe.
module tick_divider #(
    parameter int TICK_FRAMES = 30
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_newframe,
    output logic o_tick
);

    localparam int CW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_FRAMES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (i_newframe) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/playfield_arbiter.sv
// Single-port playfield RAM arbiter: video reads win, game accesses fill gaps.
// Define PLAYFIELD_WRITE_GUARD_EN to restrict game writes to blanking.
module playfield_arbiter
    import tetris_pkg::*;
#(
    parameter int TICK_FRAMES = 30
) (
    input  logic                 i_pixclk,
    input  logic                 i_reset_n,
    input  logic                 i_newframe,
    input  logic                 i_active,
    input  logic                 i_vid_req,
    input  logic [ADDR_W-1:0]    i_vid_addr,
    output logic                 o_vid_valid,
    output logic [CELL_BITS-1:0] o_vid_data,
    input  logic                 i_game_req,
    input  logic                 i_game_we,
    input  logic [ADDR_W-1:0]    i_game_addr,
    input  logic [CELL_BITS-1:0] i_game_wdata,
    output logic                 o_game_gnt,
    output logic                 o_game_rvalid,
    output logic [CELL_BITS-1:0] o_game_rdata,
    output logic                 o_tick,
    output logic                 o_mem_en,
    output logic                 o_mem_we,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [CELL_BITS-1:0] o_mem_wdata,
    input  logic [CELL_BITS-1:0] i_mem_rdata
);

    acc_state_t state_q, state_d;
    logic       oor_q, oor_d;
    logic       mem_en_q, mem_en_d;
    logic       mem_we_q, mem_we_d;
    addr_t      mem_addr_q, mem_addr_d;
    cell_t      mem_wdata_q, mem_wdata_d;
    logic       vtag_q, gtag_q, zero_q;
    logic       guard;
    logic       game_gnt;

`ifdef PLAYFIELD_WRITE_GUARD_EN
    assign guard = i_game_we & i_active;
`else
    logic unused_active;
    assign unused_active = i_active;
    assign guard = 1'b0;
`endif

    assign game_gnt = i_game_req & ~i_vid_req & ~guard;

    always_comb begin
        state_d     = IDLE;
        oor_d       = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (i_vid_req) begin
            state_d = VRD;
            oor_d   = ~in_range(i_vid_addr);
            if (!oor_d) mem_addr_d = i_vid_addr;
        end else if (game_gnt) begin
            state_d = i_game_we ? GWR : GRD;
            oor_d   = ~in_range(i_game_addr);
            if (!oor_d) begin
                mem_addr_d = i_game_addr;
                if (i_game_we) mem_wdata_d = i_game_wdata;
            end
        end
        // Out-of-range accesses keep their state but never touch the RAM.
        mem_en_d = (state_d != IDLE) & ~oor_d;
        mem_we_d = (state_d == GWR) & ~oor_d;
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            oor_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vtag_q      <= 1'b0;
            gtag_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            oor_q       <= oor_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            vtag_q      <= (state_q == VRD);
            gtag_q      <= (state_q == GRD);
            zero_q      <= oor_q;
        end
    end

    assign o_game_gnt    = game_gnt;
    assign o_mem_en      = mem_en_q;
    assign o_mem_we      = mem_we_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_wdata   = mem_wdata_q;
    assign o_vid_valid   = vtag_q;
    assign o_game_rvalid = gtag_q;
    assign o_vid_data    = (vtag_q & ~zero_q) ? i_mem_rdata : '0;
    assign o_game_rdata  = (gtag_q & ~zero_q) ? i_mem_rdata : '0;

    tick_divider #(
        .TICK_FRAMES(TICK_FRAMES)
    ) u_tick (
        .i_clk     (i_pixclk),
        .i_reset_n (i_reset_n),
        .i_newframe(i_newframe),
        .o_tick    (o_tick)
    );

endmodule

// File: tb/tb_playfield_arbiter.sv
// Bench for playfield_arbiter: directed vector table, reset/tick/guard
// sequences and a randomized run against a cycle-indexed reference model.
module tb_playfield_arbiter;

    localparam int AW = 8;
    localparam int CB = 3;
    localparam int NC = 200;
    localparam int NR = 400;
`ifdef PLAYFIELD_WRITE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          newframe, active;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [CB-1:0] vid_data;
    logic          game_req, game_we;
    logic [AW-1:0] game_addr;
    logic [CB-1:0] game_wdata;
    logic          game_gnt, game_rvalid;
    logic [CB-1:0] game_rdata;
    logic          tick;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [CB-1:0] mem_wdata;
    logic [CB-1:0] mem_rdata;
    logic          init_ram;

    int nerr = 0;
    int nchk = 0;

    playfield_arbiter #(.TICK_FRAMES(3)) dut (
        .i_pixclk     (clk),
        .i_reset_n    (rst_n),
        .i_newframe   (newframe),
        .i_active     (active),
        .i_vid_req    (vid_req),
        .i_vid_addr   (vid_addr),
        .o_vid_valid  (vid_valid),
        .o_vid_data   (vid_data),
        .i_game_req   (game_req),
        .i_game_we    (game_we),
        .i_game_addr  (game_addr),
        .i_game_wdata (game_wdata),
        .o_game_gnt   (game_gnt),
        .o_game_rvalid(game_rvalid),
        .o_game_rdata (game_rdata),
        .o_tick       (tick),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, preloaded with cell(i) = (i+6) mod 8.
    logic [CB-1:0] ram [0:NC-1];
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < NC; i++) ram[i] <= CB'(i + 6);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    function automatic logic [CB-1:0] init_cell(input int a);
        return CB'(a + 6);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".vid_valid"}, vid_valid, 0);
        chk({tag, ".vid_data"}, vid_data, 0);
        chk({tag, ".game_rvalid"}, game_rvalid, 0);
        chk({tag, ".game_rdata"}, game_rdata, 0);
        chk({tag, ".gnt"}, game_gnt, 0);
        chk({tag, ".tick"}, tick, 0);
        chk({tag, ".mem_en"}, mem_en, 0);
        chk({tag, ".mem_we"}, mem_we, 0);
        chk({tag, ".mem_addr"}, mem_addr, 0);
        chk({tag, ".mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        vid_req = 0; vid_addr = '0;
        game_req = 0; game_we = 0; game_addr = '0; game_wdata = '0;
        newframe = 0; active = 0;
    endtask

    typedef struct {
        bit            vr;
        logic [AW-1:0] va;
        bit            gr;
        bit            gw;
        logic [AW-1:0] ga;
        logic [CB-1:0] gd;
        bit            e_gnt;
        bit            e_men;
        bit            e_mwe;
        logic [AW-1:0] e_madr;
        bit            e_vv;
        logic [CB-1:0] e_vd;
        bit            e_gv;
        logic [CB-1:0] e_gdat;
    } vec_t;

    vec_t vecs [13];
    int   frames = 0;

    initial begin
        idle_in();
        rst_n    = 0;
        init_ram = 1;
        mem_rdata = '0;
        #2;
        chk_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1;
        init_ram = 0;

        // Asynchronous reset while a video read is on the RAM port.
        next_cyc();
        vid_req = 1; vid_addr = 8'd5;
        next_cyc();
        vid_req = 0;
        chk("midrd.mem_en", mem_en, 1);
        #1 rst_n = 0;
        #1 chk_zero("midrd");
        #1 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d.vid_valid", i), vid_valid, 0);
            next_cyc();
        end

        //          vr va   gr gw ga   gd gnt men mwe madr vv vd gv gdat
        vecs[0]  = '{1, 5,   0, 0, 0,   0, 0,  0,  0,  0,   0, 0, 0, 0};
        vecs[1]  = '{0, 0,   0, 0, 0,   0, 0,  1,  0,  5,   0, 0, 0, 0};
        vecs[2]  = '{1, 5,   1, 0, 7,   0, 0,  0,  0,  0,   1, 3, 0, 0};
        vecs[3]  = '{0, 0,   1, 0, 7,   0, 1,  1,  0,  5,   0, 0, 0, 0};
        vecs[4]  = '{0, 0,   1, 1, 199, 6, 1,  1,  0,  7,   1, 3, 0, 0};
        vecs[5]  = '{0, 0,   1, 0, 199, 0, 1,  1,  1,  199, 0, 0, 1, 5};
        vecs[6]  = '{0, 0,   1, 1, 200, 5, 1,  1,  0,  199, 0, 0, 0, 0};
        vecs[7]  = '{0, 0,   1, 0, 200, 0, 1,  0,  0,  0,   0, 0, 1, 6};
        vecs[8]  = '{0, 0,   0, 0, 0,   0, 0,  0,  0,  0,   0, 0, 0, 0};
        vecs[9]  = '{0, 0,   0, 0, 0,   0, 0,  0,  0,  0,   0, 0, 1, 0};
        vecs[10] = '{1, 250, 0, 0, 0,   0, 0,  0,  0,  0,   0, 0, 0, 0};
        vecs[11] = '{0, 0,   0, 0, 0,   0, 0,  0,  0,  0,   0, 0, 0, 0};
        vecs[12] = '{0, 0,   0, 0, 0,   0, 0,  0,  0,  0,   1, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            vid_req    = vecs[i].vr;
            vid_addr   = vecs[i].va;
            game_req   = vecs[i].gr;
            game_we    = vecs[i].gw;
            game_addr  = vecs[i].ga;
            game_wdata = vecs[i].gd;
            @(negedge clk);
            chk($sformatf("v%0d.gnt", i), game_gnt, vecs[i].e_gnt);
            chk($sformatf("v%0d.mem_en", i), mem_en, vecs[i].e_men);
            chk($sformatf("v%0d.mem_we", i), mem_we, vecs[i].e_mwe);
            if (vecs[i].e_men)
                chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_madr);
            chk($sformatf("v%0d.vid_valid", i), vid_valid, vecs[i].e_vv);
            chk($sformatf("v%0d.vid_data", i), vid_data, vecs[i].e_vd);
            chk($sformatf("v%0d.game_rvalid", i), game_rvalid, vecs[i].e_gv);
            chk($sformatf("v%0d.game_rdata", i), game_rdata, vecs[i].e_gdat);
            next_cyc();
        end
        idle_in();

        // Write guard: blocked while active (if enabled), reads unaffected.
        game_req = 1; game_we = 1; game_addr = 8'd3; game_wdata = 3'd2;
        active = 1;
        @(negedge clk);
        chk("guard.wr_active", game_gnt, GUARD ? 0 : 1);
        if (GUARD) begin
            next_cyc();
            @(negedge clk);
            chk("guard.wr_active2", game_gnt, 0);
            next_cyc();
            active = 0;
            @(negedge clk);
            chk("guard.wr_blank", game_gnt, 1);
        end
        next_cyc();
        active = 1; game_we = 0;
        @(negedge clk);
        chk("guard.rd_active", game_gnt, 1);
        next_cyc();
        idle_in();
        repeat (3) next_cyc();

        // Tick: one pulse per 3 frame strobes, one cycle after the strobe.
        begin : tick_test
            int nt;
            nt = 0;
            for (int p = 0; p < 6; p++) begin
                newframe = 1;
                frames++;
                @(negedge clk);
                chk($sformatf("tick.p%0d.on", p), tick, 0);
                nt += int'(tick);
                next_cyc();
                newframe = 0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk($sformatf("tick.p%0d.c%0d", p, c), tick,
                        (c == 0 && (p % 3) == 2) ? 1 : 0);
                    nt += int'(tick);
                    next_cyc();
                end
            end
            chk("tick.count", nt, 2);
        end

        // Randomized traffic against a cycle-indexed expectation model.
        init_ram = 1;
        next_cyc();
        init_ram = 0;
        next_cyc();
        begin : rnd
            logic [CB-1:0] shadow [0:NC-1];
            bit            ev [0:NR+2];
            bit            eg [0:NR+2];
            bit            et [0:NR+2];
            logic [CB-1:0] evd [0:NR+2];
            logic [CB-1:0] egd [0:NR+2];
            bit            g_pend, g_we, e_gnt;
            logic [AW-1:0] g_addr;
            logic [CB-1:0] g_data;
            for (int i = 0; i < NC; i++) shadow[i] = init_cell(i);
            for (int i = 0; i <= NR + 2; i++) begin
                ev[i] = 0; eg[i] = 0; et[i] = 0; evd[i] = '0; egd[i] = '0;
            end
            g_pend = 0; g_we = 0; g_addr = '0; g_data = '0;
            for (int k = 0; k < NR; k++) begin
                if (!g_pend && ($urandom % 2) == 1) begin
                    g_pend = 1;
                    g_we   = ($urandom % 2) == 1;
                    g_addr = ($urandom % 5 == 0) ? AW'($urandom_range(0, 255))
                                                 : AW'($urandom_range(190, 209));
                    g_data = CB'($urandom);
                end
                vid_req    = ($urandom % 10) < 4;
                vid_addr   = ($urandom % 6 == 0) ? AW'($urandom_range(0, 255))
                                                 : AW'($urandom_range(190, 209));
                game_req   = g_pend;
                game_we    = g_we;
                game_addr  = g_addr;
                game_wdata = g_data;
                newframe   = ($urandom % 8) == 0;
                active     = ($urandom % 2) == 1;
                e_gnt = g_pend && !vid_req && !(GUARD && g_we && active);
                @(negedge clk);
                chk($sformatf("r%0d.gnt", k), game_gnt, e_gnt);
                chk($sformatf("r%0d.vid_valid", k), vid_valid, ev[k]);
                chk($sformatf("r%0d.vid_data", k), vid_data, evd[k]);
                chk($sformatf("r%0d.game_rvalid", k), game_rvalid, eg[k]);
                chk($sformatf("r%0d.game_rdata", k), game_rdata, egd[k]);
                chk($sformatf("r%0d.tick", k), tick, et[k]);
                if (vid_req) begin
                    ev[k+2]  = 1;
                    evd[k+2] = (int'(vid_addr) < NC) ? shadow[vid_addr] : '0;
                end else if (e_gnt) begin
                    if (g_we) begin
                        if (int'(g_addr) < NC) shadow[g_addr] = g_data;
                    end else begin
                        eg[k+2]  = 1;
                        egd[k+2] = (int'(g_addr) < NC) ? shadow[g_addr] : '0;
                    end
                    g_pend = 0;
                end
                if (newframe) begin
                    frames++;
                    if (frames % 3 == 0) et[k+1] = 1;
                end
                next_cyc();
            end
        end
        idle_in();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
